// File: rtl/capture_replay_streamer.sv
// capture_replay_streamer: captures CAPTURE_LENGTH samples on a trigger, then replays
// them as gapped axiov/axiod bursts replay_count times.
module capture_replay_streamer #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH    = 1000,
    parameter int GAP_CYCLES        = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic [SAMPLE_DATA_WIDTH-1:0] sample_data,
    input  logic                         capture_trigger,
    input  logic [15:0]                  replay_count,
    output logic                         busy,
    output logic                         capture_done,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                         axiolast
);
    localparam int AW = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW-1:0] LAST  = AW'(CAPTURE_LENGTH - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY, GAP} state_t;

    state_t                         state_q, state_d;
    logic [AW-1:0]                  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [GW-1:0]                  gcnt_q, gcnt_d;
    logic                           busy_q, busy_d, done_q, done_d;
    logic                           axiov_q, axiov_d, last_q, last_d;
    logic [SAMPLE_DATA_WIDTH-1:0]   mem [CAPTURE_LENGTH];
    logic [SAMPLE_DATA_WIDTH-1:0]   rdata_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (capture_trigger) begin
                state_d = CAPTURE;
                wptr_d  = '0;
                cnt_d   = replay_count;
            end
            CAPTURE: if (sample_valid) begin
                wptr_d = wptr_q + 1'b1;
                if (wptr_q == LAST) begin
                    wptr_d  = '0;
                    rptr_d  = '0;
                    state_d = (cnt_q == '0) ? IDLE : REPLAY;
                    done_d  = (cnt_q == '0);
                end
            end
            REPLAY: begin
                rptr_d = rptr_q + 1'b1;
                // The last burst also passes through GAP for one cycle so that
                // capture_done lands on the cycle after the final beat.
                if (rptr_q == LAST) begin
                    rptr_d  = '0;
                    cnt_d   = cnt_q - 16'd1;
                    gcnt_d  = '0;
                    state_d = GAP;
                end
            end
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (gcnt_q == GLAST) begin
                state_d = REPLAY;
            end else begin
                gcnt_d = gcnt_q + 1'b1;
            end
        endcase
        busy_d  = state_d != IDLE;
        axiov_d = state_q == REPLAY;
        last_d  = (state_q == REPLAY) && (rptr_q == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            axiov_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            axiov_q <= axiov_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CAPTURE && sample_valid) mem[wptr_q] <= sample_data;
        rdata_q <= mem[rptr_q];
    end

    assign busy         = busy_q;
    assign capture_done = done_q;
    assign axiov        = axiov_q;
    assign axiolast     = last_q;
    assign axiod        = axiov_q ? rdata_q : '0;
endmodule

// File: tb/tb_capture_replay_streamer.sv
// tb_capture_replay_streamer: scoreboard bench with a small (8 samples, gap 3) and a
// default-parameter instance sharing the sample inputs but with separate triggers.
module tb_capture_replay_streamer;
    localparam int W  = 8;
    localparam int SL = 8;
    localparam int SG = 3;
    localparam int DL = 1000;

    logic clk = 0, rst = 1, sample_valid = 0, s_trig = 0, d_trig = 0;
    logic [W-1:0] sample_data = 0;
    logic [15:0] replay_count = 0;
    logic s_busy, s_done, s_axiov, s_last, d_busy, d_done, d_axiov, d_last;
    logic [W-1:0] s_axiod, d_axiod;

    int checks = 0, errors = 0, ncyc = 0;
    logic [W:0] s_q[$], d_q[$];
    logic [W:0] s_e, d_e;
    int s_low = 0, s_last_cyc = -100, s_done_cyc = -100, s_done_n = 0;
    bit s_gapchk = 0;
    int d_beats = 0, d_lasts = 0, d_done_n = 0, d_done_cyc = -100;
    logic [W-1:0] cap[DL];

    always #5 clk = ~clk;

    capture_replay_streamer #(.SAMPLE_DATA_WIDTH(W), .CAPTURE_LENGTH(SL), .GAP_CYCLES(SG)) u_small (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .capture_trigger(s_trig), .replay_count(replay_count), .busy(s_busy),
        .capture_done(s_done), .axiov(s_axiov), .axiod(s_axiod), .axiolast(s_last));

    capture_replay_streamer u_default (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .capture_trigger(d_trig), .replay_count(replay_count), .busy(d_busy),
        .capture_done(d_done), .axiov(d_axiov), .axiod(d_axiod), .axiolast(d_last));

    always @(negedge clk) begin
        ncyc++;
        if (s_axiov) begin
            checks++;
            if (s_q.size() == 0) begin
                errors++;
                $display("FAIL s_beat: unexpected beat axiod=%h last=%b", s_axiod, s_last);
            end else begin
                s_e = s_q.pop_front();
                if ({s_last, s_axiod} !== s_e) begin
                    errors++;
                    $display("FAIL s_beat: got last=%b axiod=%h expected last=%b axiod=%h",
                             s_last, s_axiod, s_e[W], s_e[W-1:0]);
                end
            end
            if (s_gapchk) begin
                checks++;
                if (s_low != SG) begin
                    errors++;
                    $display("FAIL s_gap: got %0d idle cycles expected %0d", s_low, SG);
                end
                s_gapchk = 0;
            end
            s_low = 0;
            if (s_last) begin
                s_last_cyc = ncyc;
                s_gapchk = 1;
            end
        end else begin
            s_low++;
            checks++;
            if (s_axiod !== '0 || s_last !== 1'b0) begin
                errors++;
                $display("FAIL s_idle_out: axiod=%h last=%b expected 0 while axiov low", s_axiod, s_last);
            end
        end
        if (s_done) begin
            s_done_n++;
            s_done_cyc = ncyc;
            s_gapchk = 0;
            checks++;
            if (s_busy !== 1'b0) begin
                errors++;
                $display("FAIL s_busy_at_done: busy=%b expected 0", s_busy);
            end
        end
        if (d_axiov) begin
            d_beats++;
            if (d_last) d_lasts++;
            checks++;
            if (d_q.size() == 0) begin
                errors++;
                $display("FAIL d_beat: unexpected beat axiod=%h", d_axiod);
            end else begin
                d_e = d_q.pop_front();
                if ({d_last, d_axiod} !== d_e) begin
                    errors++;
                    $display("FAIL d_beat: got last=%b axiod=%h expected last=%b axiod=%h",
                             d_last, d_axiod, d_e[W], d_e[W-1:0]);
                end
            end
        end
        if (d_done) begin
            d_done_n++;
            d_done_cyc = ncyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_start(input logic [15:0] cnt, input bit coinc);
        s_gapchk = 0;
        step();
        s_trig = 1; replay_count = cnt; sample_valid = coinc; sample_data = 8'hFF;
        step();
        s_trig = 0; sample_valid = 0;
        checks++;
        if (s_busy !== 1'b1) begin
            errors++;
            $display("FAIL s_busy_rise: busy=%b expected 1", s_busy);
        end
    endtask

    task automatic s_feed(input logic [W-1:0] base, input bit gapped, input int bursts, output int t_last);
        t_last = 0;
        for (int b = 0; b < bursts; b++)
            for (int i = 0; i < SL; i++) s_q.push_back({i == SL - 1, base + W'(i)});
        for (int i = 0; i < SL; i++) begin
            sample_valid = 1; sample_data = base + W'(i);
            if (i == SL - 1) t_last = ncyc + 1;
            step();
            if (gapped) begin
                sample_valid = 0; sample_data = 8'hEE;
                step();
            end
        end
        sample_valid = 0; sample_data = 0;
    endtask

    task automatic s_wait_done(input string name, input int exp_cyc, input int n0);
        int k = 0;
        while (s_done_n == n0 && k < 2000) begin step(); k++; end
        checks++;
        if (s_done_n == n0) begin
            errors++;
            $display("FAIL %s_timeout: capture_done never pulsed", name);
        end else if (s_done_cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s_done_cycle: got cycle %0d expected %0d", name, s_done_cyc, exp_cyc);
        end
        repeat (20) step();
        checks++;
        if (s_done_n != n0 + 1 || s_q.size() != 0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: done pulses=%0d expected 1, beats left=%0d expected 0, busy=%b expected 0",
                     name, s_done_n - n0, s_q.size(), s_busy);
        end
    endtask

    task automatic test_reset();
        #2 rst = 0;
        #2;
        checks++;
        if ({s_busy, s_done, s_axiov, s_last, s_axiod, d_busy, d_done, d_axiov, d_last, d_axiod} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: small busy=%b done=%b v=%b last=%b d=%h, default busy=%b done=%b v=%b last=%b d=%h expected all 0",
                     s_busy, s_done, s_axiov, s_last, s_axiod, d_busy, d_done, d_axiov, d_last, d_axiod);
        end
        repeat (3) step();
        rst = 1;
        step();
    endtask

    task automatic test_basic();
        int t, n0 = s_done_n;
        s_start(16'd2, 0);
        s_feed(8'h10, 0, 2, t);
        s_wait_done("basic", t + 2 + (SL + SG) + SL, n0);
    endtask

    task automatic test_gapped_input();
        int t, n0 = s_done_n;
        s_start(16'd2, 0);
        s_feed(8'hA0, 1, 2, t);
        s_wait_done("gapped", t + 2 + (SL + SG) + SL, n0);
    endtask

    task automatic test_zero_count();
        int t, n0 = s_done_n;
        s_start(16'd0, 0);
        s_feed(8'h20, 0, 0, t);
        s_wait_done("zero_count", t + 1, n0);
    endtask

    task automatic test_trigger_in_replay();
        int t, k = 0, n0 = s_done_n;
        s_start(16'd2, 0);
        s_feed(8'h40, 0, 2, t);
        while (!s_axiov && k < 50) begin step(); k++; end
        step();
        s_trig = 1; replay_count = 16'd5;
        step();
        s_trig = 0;
        s_wait_done("trig_in_replay", t + 2 + (SL + SG) + SL, n0);
    endtask

    task automatic test_coincident_sample();
        int t, n0 = s_done_n;
        s_start(16'd1, 1);
        s_feed(8'h30, 0, 1, t);
        s_wait_done("coincident", t + 2 + SL, n0);
    endtask

    task automatic test_mid_reset();
        int t, k = 0, n0;
        s_start(16'd2, 0);
        s_feed(8'h50, 0, 2, t);
        while (!(s_axiov && s_axiod == 8'h54) && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (k >= 100) begin
            errors++;
            $display("FAIL mid_reset_wait: beat 0x54 never seen");
        end
        #2 rst = 0;
        #1;
        checks++;
        if ({s_axiov, s_last, s_busy, s_done, s_axiod} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: v=%b last=%b busy=%b done=%b d=%h expected all 0",
                     s_axiov, s_last, s_busy, s_done, s_axiod);
        end
        s_q.delete();
        s_gapchk = 0;
        n0 = s_done_n;
        step();
        rst = 1;
        repeat (30) step();
        checks++;
        if (s_done_n != n0 || s_axiov !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: done pulses=%0d axiov=%b expected 0 and 0", s_done_n - n0, s_axiov);
        end
        s_start(16'd1, 0);
        s_feed(8'h60, 0, 1, t);
        s_wait_done("after_reset", t + 2 + SL, n0);
    endtask

    task automatic test_default_params();
        int t = 0, k = 0, n0 = d_done_n;
        for (int i = 0; i < DL; i++) cap[i] = W'($urandom_range(0, 255));
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < DL; i++) d_q.push_back({i == DL - 1, cap[i]});
        step();
        d_trig = 1; replay_count = 16'd3;
        step();
        d_trig = 0;
        for (int i = 0; i < DL; i++) begin
            sample_valid = 1; sample_data = cap[i];
            if (i == DL - 1) t = ncyc + 1;
            step();
        end
        sample_valid = 0; sample_data = 0;
        while (d_done_n == n0 && k < 6000) begin step(); k++; end
        checks++;
        if (d_done_n == n0) begin
            errors++;
            $display("FAIL default_timeout: capture_done never pulsed");
        end else if (d_done_cyc != t + 2 + 2 * (DL + 1) + DL) begin
            errors++;
            $display("FAIL default_done_cycle: got %0d expected %0d", d_done_cyc, t + 2 + 2 * (DL + 1) + DL);
        end
        repeat (5) step();
        checks++;
        if (d_beats != 3 * DL || d_lasts != 3 || d_q.size() != 0 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL default_totals: beats=%0d lasts=%0d left=%0d busy=%b expected %0d, 3, 0, 0",
                     d_beats, d_lasts, d_q.size(), d_busy, 3 * DL);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped_input();
        test_zero_count();
        test_trigger_in_replay();
        test_coincident_sample();
        test_mid_reset();
        test_default_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
